hazard_pattern_ctrl: RTL

//  Downstream of the button-conditioning stage. Consumes its 1-cycle release pulse as a mode-advance

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_pattern_ctrl_step_prescaler.sv | 29 ++
 rtl/hazard_pattern_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - mode encoding, lamp patterns and mode sequencing helpers for the hazard lamp controller
package hazard_pkg;

  typedef enum logic [1:0] {
    CALM = 2'd0,
    R2L  = 2'd1,
    L2R  = 2'd2
  } mode_t;

  // leds[2] is the leftmost lamp
  localparam logic [2:0] P_CALM0 = 3'b101;
  localparam logic [2:0] P_CALM1 = 3'b010;
  localparam logic [2:0] P_R2L0  = 3'b001;
  localparam logic [2:0] P_R2L1  = 3'b010;
  localparam logic [2:0] P_R2L2  = 3'b100;
  localparam logic [2:0] P_L2R0  = 3'b100;
  localparam logic [2:0] P_L2R1  = 3'b010;
  localparam logic [2:0] P_L2R2  = 3'b001;

  function automatic mode_t next_mode(mode_t m);
    case (m)
      CALM:    return R2L;
      R2L:     return L2R;
      default: return CALM;
    endcase
  endfunction

  function automatic logic [1:0] phase_max(mode_t m);
    case (m)
      CALM:     return 2'd1;
      R2L, L2R: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_pattern_ctrl_step_prescaler.sv
// rtl/hazard_pattern_ctrl_step_prescaler.sv - step_prescaler: counts 0..STEP_DIV-1, flags the wrap cycle
module step_prescaler #(
  parameter int STEP_DIV = 8,
  parameter int CNT_W    = $clog2(STEP_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_pattern_ctrl.sv
// rtl/hazard_pattern_ctrl.sv - hazard lamp mode/phase FSM with prescaled stepping; HAZARD_PAUSE_EN adds the hold input
module hazard_pattern_ctrl
  import hazard_pkg::*;
#(
  parameter int STEP_DIV = 8,
  parameter int CNT_W    = $clog2(STEP_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_pulse,
`ifdef HAZARD_PAUSE_EN
  input  logic       hold,
`endif
  output logic [2:0] leds,
  output logic [1:0] mode,
  output logic       step_stb
);

  logic [1:0] mode_q;
  logic [1:0] phase_q;
  logic       hold_i;
  logic       bad;
  logic       wrap;

`ifdef HAZARD_PAUSE_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  // An unreachable encoding (mode 3 or phase past the mode's last step) self-heals to CALM
  assign bad = (mode_q == 2'd3) || (phase_q > phase_max(mode_t'(mode_q)));

  step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (mode_pulse || bad),
    .en    (!hold_i),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q   <= CALM;
      phase_q  <= 2'd0;
      step_stb <= 1'b0;
    end else if (bad) begin
      mode_q   <= CALM;
      phase_q  <= 2'd0;
      step_stb <= 1'b0;
    end else if (mode_pulse) begin
      mode_q   <= next_mode(mode_t'(mode_q));
      phase_q  <= 2'd0;
      step_stb <= 1'b0;
    end else if (wrap) begin
      phase_q  <= (phase_q == phase_max(mode_t'(mode_q))) ? 2'd0 : phase_q + 2'd1;
      step_stb <= 1'b1;
    end else begin
      step_stb <= 1'b0;
    end
  end

  always_comb begin
    leds = 3'b000;
    case (mode_t'(mode_q))
      CALM: begin
        case (phase_q)
          2'd0:    leds = P_CALM0;
          2'd1:    leds = P_CALM1;
          default: leds = 3'b000;
        endcase
      end
      R2L: begin
        case (phase_q)
          2'd0:    leds = P_R2L0;
          2'd1:    leds = P_R2L1;
          2'd2:    leds = P_R2L2;
          default: leds = 3'b000;
        endcase
      end
      L2R: begin
        case (phase_q)
          2'd0:    leds = P_L2R0;
          2'd1:    leds = P_L2R1;
          2'd2:    leds = P_L2R2;
          default: leds = 3'b000;
        endcase
      end
      default: leds = 3'b000;
    endcase
  end

  assign mode = mode_q;

endmodule
